// File: rtl/stage_sequencer.sv
// Multicycle MIPS control sequencer: walks IF/ID/EX/MEM/WB, decodes in ID, drives registered strobes.
// Latency: one stage per unstalled cycle; outputs registered, valid the cycle after the selecting edge.
// Backpressure: stall freezes all state and outputs (ignored in HALT); STAGE_SKIP_EN skips unused stages.
module stage_sequencer #(
    parameter int OPCODE_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [2:0]          stage,
    output logic                regWrite,
    output logic                regDest,
    output logic                memRead,
    output logic                memWrite,
    output logic                branch,
    output logic                pcWrite,
    output logic                halted,
    output logic [31:0]         instrCount
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_RTYPE,
        C_ADDI,
        C_LW,
        C_SW,
        C_BR,
        C_HALT
    } cls_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(6'b111111);

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    logic   retire;

    function automatic cls_t decode(input logic [OPCODE_W-1:0] op);
        cls_t c;
        case (op)
            OP_RTYPE:      c = C_RTYPE;
            OP_ADDI:       c = C_ADDI;
            OP_LW:         c = C_LW;
            OP_SW:         c = C_SW;
            OP_BEQ, OP_J:  c = C_BR;
            OP_HALT:       c = C_HALT;
            default:       c = C_NOP;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        retire  = 1'b0;
        if (!stall) begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    cls_d   = decode(opcode);
                    state_d = (cls_d == C_HALT) ? S_HALT : S_EX;
                end
`ifdef STAGE_SKIP_EN
                S_EX: begin
                    case (cls_q)
                        C_RTYPE, C_ADDI: state_d = S_WB;
                        C_LW, C_SW:      state_d = S_MEM;
                        default:         state_d = S_IF;
                    endcase
                end
                S_MEM:   state_d = (cls_q == C_SW) ? S_IF : S_WB;
`else
                S_EX:    state_d = S_MEM;
                S_MEM:   state_d = S_WB;
`endif
                S_WB:    state_d = S_IF;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IF;
            endcase
        end
        // Any return to IF from an execute-side stage is a retirement; reset is not.
        if ((state_q == S_EX || state_q == S_MEM || state_q == S_WB) && state_d == S_IF) begin
            retire = 1'b1;
        end
    end

    // Strobes are computed from the stage/class being entered, so they line up with stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IF;
            cls_q      <= C_NOP;
            regWrite   <= 1'b0;
            regDest    <= 1'b0;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            branch     <= 1'b0;
            pcWrite    <= 1'b1;
            halted     <= 1'b0;
            instrCount <= 32'd0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            regWrite <= (state_d == S_WB) &&
                        (cls_d == C_RTYPE || cls_d == C_ADDI || cls_d == C_LW);
            regDest  <= (state_d == S_WB) && (cls_d == C_RTYPE);
            memRead  <= (state_d == S_MEM) && (cls_d == C_LW);
            memWrite <= (state_d == S_MEM) && (cls_d == C_SW);
            branch   <= (state_d == S_EX) && (cls_d == C_BR);
            pcWrite  <= (state_d == S_IF);
            halted   <= halted | (state_d == S_HALT);
            if (retire) begin
                instrCount <= instrCount + 32'd1;
            end
        end
    end

    assign stage = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus randomized traffic against a per-instruction route model.
module tb_stage_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [5:0]  opcode;
    logic [2:0]  stage;
    logic        regWrite, regDest, memRead, memWrite, branch, pcWrite, halted;
    logic [31:0] instrCount;

    int checks = 0;
    int errors = 0;

    localparam int K_NOP = 0, K_R = 1, K_ADDI = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_HALT = 6;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_NOP  = 6'b010101;

    // Model: current stage, class, remaining stages of the instruction's route.
    int          m_stage;
    int          m_cls;
    int          path[$];
    logic [31:0] m_count;
    bit          m_halted;

    stage_sequencer #(.OPCODE_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .opcode     (opcode),
        .stage      (stage),
        .regWrite   (regWrite),
        .regDest    (regDest),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .branch     (branch),
        .pcWrite    (pcWrite),
        .halted     (halted),
        .instrCount (instrCount)
    );

    always #5 clock = ~clock;

    function automatic int classify(input logic [5:0] op);
        case (op)
            OP_R:          return K_R;
            OP_ADDI:       return K_ADDI;
            OP_LW:         return K_LW;
            OP_SW:         return K_SW;
            OP_BEQ, OP_J:  return K_BR;
            OP_HALT:       return K_HALT;
            default:       return K_NOP;
        endcase
    endfunction

    task automatic set_path(input int c);
`ifdef STAGE_SKIP_EN
        case (c)
            K_R, K_ADDI: path = '{2, 4};
            K_SW:        path = '{2, 3};
            K_LW:        path = '{2, 3, 4};
            default:     path = '{2};
        endcase
`else
        path = '{2, 3, 4};
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [5:0] op);
        reset  = r;
        stall  = s;
        opcode = op;
        @(posedge clock);
        if (r) begin
            m_stage  = 0;
            m_cls    = K_NOP;
            m_count  = 32'd0;
            m_halted = 1'b0;
            path.delete();
        end else if (m_halted || s) begin
            // frozen
        end else if (m_stage == 0) begin
            m_stage = 1;
        end else if (m_stage == 1) begin
            m_cls = classify(op);
            if (m_cls == K_HALT) begin
                m_stage  = 7;
                m_halted = 1'b1;
            end else begin
                set_path(m_cls);
                m_stage = path.pop_front();
            end
        end else if (path.size() == 0) begin
            m_count = m_count + 32'd1;
            m_stage = 0;
        end else begin
            m_stage = path.pop_front();
        end
        #1;
        chk("stage",      32'(stage),    32'(m_stage));
        chk("pcWrite",    32'(pcWrite),  32'(m_stage == 0));
        chk("regWrite",   32'(regWrite), 32'(m_stage == 4 && (m_cls == K_R || m_cls == K_ADDI || m_cls == K_LW)));
        chk("regDest",    32'(regDest),  32'(m_stage == 4 && m_cls == K_R));
        chk("memRead",    32'(memRead),  32'(m_stage == 3 && m_cls == K_LW));
        chk("memWrite",   32'(memWrite), 32'(m_stage == 3 && m_cls == K_SW));
        chk("branch",     32'(branch),   32'(m_stage == 2 && m_cls == K_BR));
        chk("halted",     32'(halted),   32'(m_halted));
        chk("instrCount", instrCount,    m_count);
    endtask

    // Runs until the instruction retires to IF or halts; the given opcode is presented in ID.
    task automatic run_instr(input logic [5:0] op);
        int n = 0;
        do begin
            step(1'b0, 1'b0, (m_stage == 1) ? op : 6'($urandom));
            n++;
        end while (m_stage != 0 && m_stage != 7 && n < 12);
    endtask

    initial begin
        logic [5:0] ops [7];
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_NOP};
        m_stage  = 0;
        m_cls    = K_NOP;
        m_count  = 32'd0;
        m_halted = 1'b0;
        reset = 1'b1;
        stall = 1'b0;
        opcode = 6'd0;

        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b0, 6'd0);

        run_instr(OP_R);
        run_instr(OP_LW);
        run_instr(OP_SW);

        // lw stalled three cycles in MEM
        step(1'b0, 1'b0, 6'($urandom));
        step(1'b0, 1'b0, OP_LW);
        step(1'b0, 1'b0, 6'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'($urandom));
        step(1'b0, 1'b0, 6'($urandom));
        step(1'b0, 1'b0, 6'($urandom));

        // counter wrap: preload all-ones while no retirement is in flight
        force dut.instrCount = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        step(1'b0, 1'b0, 6'($urandom));
        release dut.instrCount;
        run_instr(OP_NOP);

        // abort an R-type in EX
        step(1'b0, 1'b0, 6'($urandom));
        step(1'b0, 1'b0, OP_R);
        step(1'b1, 1'b0, 6'($urandom));
        run_instr(OP_ADDI);
        run_instr(OP_BEQ);
        run_instr(OP_J);

        // halt holds through stall toggling until reset
        run_instr(OP_HALT);
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 6'($urandom));
        step(1'b1, 1'b0, 6'd0);

        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic       s;
            logic [5:0] op;
            int         k;
            r = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) == 0);
            k = int'($urandom_range(0, 15));
            if (k < 7)       op = ops[k];
            else if (k == 7) op = OP_HALT;
            else             op = 6'($urandom);
            step(r, s, op);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
